// File: rtl/isp_ram.sv
// isp_ram: dual-port instruction RAM with a serial byte loader.
// Port A is a read-only fetch port. Port B is a read/write bus port with byte enables.
// The loader packs bytes into words and writes them through the single write port.
// The loader has priority on that write port.
module isp_ram #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RAM_DEPTH = 65536,
  parameter int unsigned READ_FWD  = 1,
  localparam int unsigned NB       = DATA_W / 8,
  localparam int unsigned AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [AW-1:0]     addra,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic [NB-1:0]     web,
  input  logic [AW-1:0]     addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              b_err,
  input  logic              ld_start,
  input  logic [AW-1:0]     ld_base,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [CW-1:0]     ld_count
);

  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t              state;
  logic [AW-1:0]       wptr;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   word;
  logic                last_q;
  logic [DATA_W-1:0]   mem [RAM_DEPTH];

  logic                b_wr_c;
  logic                b_rej_c;
  logic [NB-1:0]       we_c;
  logic [AW-1:0]       waddr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   rda_c;
  logic [DATA_W-1:0]   rdb_c;

  // Write-port arbitration: the loader's WRITE cycle wins, and bus writes are refused while it is busy.
  always_comb begin
    b_wr_c  = 1'b0;
    b_rej_c = 1'b0;
    we_c    = '0;
    waddr_c = addrb;
    wdata_c = dinb;
    if (enb && (web != '0)) begin
      b_wr_c  = (state == IDLE);
      b_rej_c = (state != IDLE);
    end
    if (state == WRITE) begin
      we_c    = '1;
      waddr_c = wptr;
      wdata_c = word;
    end else if (b_wr_c) begin
      we_c = web;
    end
  end

  // Read data for both ports.
  // When READ_FWD is set, lanes being written at the same address are forwarded.
  always_comb begin
    rda_c = mem[addra];
    rdb_c = mem[addrb];
    if (READ_FWD != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (we_c[i] && (addra == waddr_c)) rda_c[8*i +: 8] = wdata_c[8*i +: 8];
        if (we_c[i] && (addrb == waddr_c)) rdb_c[8*i +: 8] = wdata_c[8*i +: 8];
      end
    end
  end

  // Byte-lane memory write.
  // The array has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we_c[i]) mem[waddr_c][8*i +: 8] <= wdata_c[8*i +: 8];
    end
  end

  // Registered read ports.
  // b_err flags a refused bus write one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta <= '0;
      doutb <= '0;
      b_err <= 1'b0;
    end else begin
      if (ena) douta <= rda_c;
      if (enb && ((web == '0) || b_wr_c)) doutb <= rdb_c;
      b_err <= b_rej_c;
    end
  end

  // Loader FSM.
  // Handshake outputs are registered from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      idx      <= '0;
      word     <= '0;
      last_q   <= 1'b0;
      ld_count <= '0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            wptr     <= ld_base;
            idx      <= '0;
            word     <= '0;
            last_q   <= 1'b0;
            ld_count <= '0;
            state    <= LOAD;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid && ld_ready) begin
            word[{idx, 3'b000} +: 8] <= ld_byte;
            idx <= idx + IW'(1);
            if ((idx == IW'(NB - 1)) || ld_last) begin
              state    <= WRITE;
              last_q   <= ld_last;
              ld_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          wptr <= (wptr == AW'(RAM_DEPTH - 1)) ? '0 : wptr + AW'(1);
          if (ld_count != CW'(RAM_DEPTH)) ld_count <= ld_count + CW'(1);
          word <= '0;
          idx  <= '0;
          if (last_q) begin
            state    <= IDLE;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b1;
            ld_ready <= 1'b0;
          end else begin
            state    <= LOAD;
            ld_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
